bus_decode_ctrl: RTL and testbench
==================================

BUS_DECODE_CTRL -- requirements
Module: bus_decode_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning request address width.
REQ-002 SHALL have parameter REGION_W, default 4, meaning number of top address bits selecting a region.
REQ-003 SHALL have parameter NDEV, default 7, meaning mapped device count, legal range 1..2**REGION_W.
REQ-004 SHALL have parameter DID_W, default 3, meaning device-ID width, at least clog2(NDEV).
REQ-005 SHALL have parameter TIMEOUT, default 16, meaning maximum ACCESS cycles before bus error.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have ports rd and wr, input, 1 each, master request strobes held until done.
REQ-009 SHALL have port addr, input, ADDR_W, request address.
REQ-010 SHALL have port dev_ready, input, NDEV, per-device access-complete.
REQ-011 SHALL have port dev_sel, output, NDEV, one-hot device select.
REQ-012 SHALL have ports dev_rd and dev_wr, output, 1 each, qualified strobes to the selected device.
REQ-013 SHALL have ports hit (output, 1) and did (output, DID_W): registered decode result.
REQ-014 SHALL have ports busy, done, err, output, 1 each: transaction status.

Function
REQ-015 SHALL decode region = addr[ADDR_W-1 -: REGION_W]; hit=1 and did=region iff region < NDEV, else hit=0, did=0.
REQ-016 SHALL implement FSM states IDLE, ACCESS, DONE, ERROR.
REQ-017 In IDLE with rd XOR wr, SHALL capture addr/op and go to ACCESS if mapped, else to ERROR.
REQ-018 In IDLE with rd AND wr both high, SHALL go to ERROR with hit=0, did=0.
REQ-019 In IDLE with neither strobe, SHALL stay in IDLE with no outputs changed.
REQ-020 In ACCESS, SHALL drive dev_sel[did]=1 plus dev_rd or dev_wr per captured op; all other dev_sel bits 0.
REQ-021 In ACCESS, when dev_ready[did]=1, SHALL go to DONE next cycle; dev_ready of unselected devices SHALL be ignored.
REQ-022 DONE SHALL last exactly one cycle with done=1, err=0, then return to IDLE.
REQ-023 ERROR SHALL last exactly one cycle with done=1, err=1, then return to IDLE.
REQ-024 busy SHALL be 1 in ACCESS, DONE and ERROR; 0 in IDLE.
REQ-025 hit/did SHALL update only on capture in IDLE and hold through DONE/ERROR.
REQ-026 Strobe or addr changes outside IDLE SHALL be ignored; a strobe still high in IDLE after done SHALL start a new transaction.
REQ-027 Minimum latency: strobe sampled at edge N, ACCESS at N+1, ready at N+1 gives done at N+2.

Reset
REQ-028 rst SHALL force IDLE immediately, including mid-transaction, with no done pulse.
REQ-029 During reset, dev_sel, dev_rd, dev_wr, hit, did, busy, done and err SHALL all be 0, and the timeout counter SHALL be 0.

Configuration
REQ-030 With BUS_DECODE_TIMEOUT_EN defined, SHALL count ACCESS cycles from 0; if ready is absent after TIMEOUT cycles, SHALL go to ERROR, keeping hit/did.
REQ-031 Ready in the same cycle as the final count SHALL win, giving DONE.
REQ-032 Without BUS_DECODE_TIMEOUT_EN, ACCESS SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-033 The shared package bus_pkg SHALL hold the FSM state enum and the device-ID enum DRAM=0, DROM=1, DMAT=2, DINT=3, DREG=4, DEXEC=5, DSPI=6.
REQ-034 The combinational region decode (REQ-015) SHALL be the sub-module bus_region_decode; everything else is in bus_decode_ctrl.

Verification
REQ-035 Read 0x1ABC, dev_ready[1] high at first ACCESS cycle -> dev_sel=0000010, dev_rd=1, hit=1, did=1, done pulse 2 cycles after strobe, err=0.
REQ-036 Write 0x6FFF, dev_ready[6] after 3 ACCESS cycles -> dev_wr=1 for 3 cycles, did=6, single done pulse.
REQ-037 Reads of 0x7000 and 0xF000, and rd=wr=1 at 0x0000 -> no dev_sel, hit=0, did=0, done=err=1 one cycle after strobe.
REQ-038 With BUS_DECODE_TIMEOUT_EN and TIMEOUT=16, read 0x3000 with dev_ready held 0 -> err pulse after 16 ACCESS cycles, did=3, hit=1; dev_ready[2]=1 meanwhile has no effect.
REQ-039 rst asserted in ACCESS of a 0x4000 write -> same-cycle busy=0, dev_sel=0, no done; a fresh 0x0000 read afterward completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the bus decode controller: FSM state encoding and the
// fixed device-ID map of the address regions.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERROR  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        DRAM  = 3'd0,
        DROM  = 3'd1,
        DMAT  = 3'd2,
        DINT  = 3'd3,
        DREG  = 3'd4,
        DEXEC = 3'd5,
        DSPI  = 3'd6
    } dev_id_t;

endpackage

// File: rtl/bus_region_decode.sv
// Combinational region decode: the top REGION_W address bits pick a device;
// regions at or beyond NDEV are unmapped and report hit=0, did=0.
module bus_region_decode
    import bus_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int REGION_W = 4,
    parameter int NDEV     = 7,
    parameter int DID_W    = 3
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [DID_W-1:0]  did
);

    logic [REGION_W-1:0] region_s;
    logic                addr_unused_s;

    assign region_s      = addr[ADDR_W-1 -: REGION_W];
    // Low address bits are offsets inside a device and play no part in the decode.
    assign addr_unused_s = ^addr;

    // Region lookup against the mapped device count.
    always_comb begin
        hit = 1'b0;
        did = {DID_W{1'b0}};
        if (32'(region_s) < 32'(NDEV)) begin
            hit = 1'b1;
            did = DID_W'(region_s);
        end else begin
            hit = 1'b0;
            did = {DID_W{1'b0}};
        end
    end

endmodule

// File: rtl/bus_decode_ctrl.sv
// Bus decode controller: captures a master request, selects the addressed device
// and reports done/err. Optional ACCESS timeout enabled by BUS_DECODE_TIMEOUT_EN.
module bus_decode_ctrl
    import bus_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int REGION_W = 4,
    parameter int NDEV     = 7,
    parameter int DID_W    = 3,
    parameter int TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [NDEV-1:0]   dev_ready,
    output logic [NDEV-1:0]   dev_sel,
    output logic              dev_rd,
    output logic              dev_wr,
    output logic              hit,
    output logic [DID_W-1:0]  did,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t             state_r, state_s;
    logic               dec_hit_s;
    logic [DID_W-1:0]   dec_did_s;
    logic               hit_r, hit_s;
    logic [DID_W-1:0]   did_r, did_s;
    logic               op_wr_r, op_wr_s;
    logic [NDEV-1:0]    dev_sel_r, sel_s;
    logic               dev_rd_r, dev_wr_r, busy_r, done_r, err_r;
    logic               ready_s;

`ifdef BUS_DECODE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    bus_region_decode #(
        .ADDR_W   (ADDR_W),
        .REGION_W (REGION_W),
        .NDEV     (NDEV),
        .DID_W    (DID_W)
    ) u_decode (
        .addr (addr),
        .hit  (dec_hit_s),
        .did  (dec_did_s)
    );

    // Only the selected device's ready counts; the registered one-hot select masks the rest.
    assign ready_s = |(dev_ready & dev_sel_r);

    // Next-state, capture and next-output logic.
    always_comb begin
        state_s = state_r;
        hit_s   = hit_r;
        did_s   = did_r;
        op_wr_s = op_wr_r;
        sel_s   = {NDEV{1'b0}};
`ifdef BUS_DECODE_TIMEOUT_EN
        cnt_s   = {CNT_W{1'b0}};
`endif
        case (state_r)
            IDLE: begin
                if (rd && wr) begin
                    state_s = ERROR;
                    hit_s   = 1'b0;
                    did_s   = {DID_W{1'b0}};
                end else if (rd ^ wr) begin
                    hit_s   = dec_hit_s;
                    did_s   = dec_did_s;
                    op_wr_s = wr;
                    state_s = dec_hit_s ? ACCESS : ERROR;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (ready_s) begin
                    state_s = DONE;
`ifdef BUS_DECODE_TIMEOUT_EN
                end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    state_s = ERROR;
                end else begin
                    state_s = ACCESS;
                    cnt_s   = cnt_r + CNT_W'(1);
                end
`else
                end else begin
                    state_s = ACCESS;
                end
`endif
            end
            DONE:    state_s = IDLE;
            ERROR:   state_s = IDLE;
            default: state_s = IDLE;
        endcase

        for (int i = 0; i < NDEV; i++) begin
            if ((state_s == ACCESS) && (did_s == DID_W'(i))) begin
                sel_s[i] = 1'b1;
            end else begin
                sel_s[i] = 1'b0;
            end
        end
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            hit_r     <= 1'b0;
            did_r     <= {DID_W{1'b0}};
            op_wr_r   <= 1'b0;
            dev_sel_r <= {NDEV{1'b0}};
            dev_rd_r  <= 1'b0;
            dev_wr_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            hit_r     <= hit_s;
            did_r     <= did_s;
            op_wr_r   <= op_wr_s;
            dev_sel_r <= sel_s;
            dev_rd_r  <= (state_s == ACCESS) && !op_wr_s;
            dev_wr_r  <= (state_s == ACCESS) && op_wr_s;
            busy_r    <= (state_s != IDLE);
            done_r    <= (state_s == DONE) || (state_s == ERROR);
            err_r     <= (state_s == ERROR);
        end
    end

`ifdef BUS_DECODE_TIMEOUT_EN
    // ACCESS cycle counter, zero outside ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_s;
        end
    end
`endif

    assign dev_sel = dev_sel_r;
    assign dev_rd  = dev_rd_r;
    assign dev_wr  = dev_wr_r;
    assign hit     = hit_r;
    assign did     = did_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;

endmodule

// File: tb/tb_bus_decode_ctrl.sv
// Directed self-checking bench for bus_decode_ctrl; the timeout scenario runs
// only when BUS_DECODE_TIMEOUT_EN is defined.
module tb_bus_decode_ctrl;

    logic        clk;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [6:0]  dev_ready;
    logic [6:0]  dev_sel;
    logic        dev_rd;
    logic        dev_wr;
    logic        hit;
    logic [2:0]  did;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    bus_decode_ctrl #(
        .ADDR_W   (16),
        .REGION_W (4),
        .NDEV     (7),
        .DID_W    (3),
        .TIMEOUT  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .dev_ready (dev_ready),
        .dev_sel   (dev_sel),
        .dev_rd    (dev_rd),
        .dev_wr    (dev_wr),
        .hit       (hit),
        .did       (did),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0000; dev_ready = 7'b0000000;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({dev_sel, dev_rd, dev_wr, hit, did, busy, done, err} !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0000", {dev_sel, dev_rd, dev_wr, hit, did, busy, done, err});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, err} !== 3'b000) begin
            n_err++; $display("FAIL reset_idle: got %b want 000", {busy, done, err});
        end
    endtask

    task automatic test_read();
        rd = 1'b1; addr = 16'h1ABC;
        @(negedge clk);
        n_cmp++;
        if (dev_sel !== 7'b0000010) begin n_err++; $display("FAIL read_sel: got %b want 0000010", dev_sel); end
        n_cmp++;
        if ({dev_rd, dev_wr} !== 2'b10) begin n_err++; $display("FAIL read_strobe: got %b want 10", {dev_rd, dev_wr}); end
        n_cmp++;
        if ({hit, did} !== 4'b1001) begin n_err++; $display("FAIL read_hitdid: got %b want 1001", {hit, did}); end
        n_cmp++;
        if ({busy, done, err} !== 3'b100) begin n_err++; $display("FAIL read_access: got %b want 100", {busy, done, err}); end
        dev_ready = 7'b0000010;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, err, dev_sel} !== 10'b110_0000000) begin
            n_err++; $display("FAIL read_done: got %b want 1100000000", {busy, done, err, dev_sel});
        end
        rd = 1'b0; dev_ready = 7'b0000000;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, err, hit, did} !== 7'b000_1001) begin
            n_err++; $display("FAIL read_idle_hold: got %b want 0001001", {busy, done, err, hit, did});
        end
    endtask

    task automatic test_write();
        wr = 1'b1; addr = 16'h6FFF; dev_ready = 7'b0111111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({dev_sel, dev_rd, dev_wr, hit, did, done} !== 14'b1000000_01_1_110_0) begin
                n_err++;
                $display("FAIL write_access%0d: got %b want 10000000111100", k, {dev_sel, dev_rd, dev_wr, hit, did, done});
            end
            if (k == 0) addr = 16'h1000;
            if (k == 2) dev_ready = 7'b1000000;
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done, err, dev_wr} !== 4'b1100) begin
            n_err++; $display("FAIL write_done: got %b want 1100", {busy, done, err, dev_wr});
        end
        wr = 1'b0; dev_ready = 7'b0000000;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, hit, did} !== 6'b00_1110) begin
            n_err++; $display("FAIL write_single_done: got %b want 001110", {busy, done, hit, did});
        end
    endtask

    task automatic test_unmapped();
        logic [15:0] va [3] = '{16'h0000, 16'h7000, 16'hF000};
        logic [2:0]  vw     = 3'b100;
        for (int i = 0; i < 3; i++) begin
            rd = 1'b1; wr = vw[2-i]; addr = va[i];
            @(negedge clk);
            n_cmp++;
            if ({busy, done, err, hit, did, dev_sel, dev_rd, dev_wr} !== 16'b111_0000_0000000_00) begin
                n_err++;
                $display("FAIL unmapped%0d: got %b want 1110000000000000", i, {busy, done, err, hit, did, dev_sel, dev_rd, dev_wr});
            end
            rd = 1'b0; wr = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({busy, done, err} !== 3'b000) begin
                n_err++; $display("FAIL unmapped%0d_end: got %b want 000", i, {busy, done, err});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_busy = 5'b11011;
        logic [4:0] exp_done = 5'b01001;
        rd = 1'b1; addr = 16'h2000; dev_ready = 7'b0000100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done, err} !== {exp_busy[4-i], exp_done[4-i], 1'b0}) begin
                n_err++;
                $display("FAIL b2b_cycle%0d: got %b want %b", i, {busy, done, err}, {exp_busy[4-i], exp_done[4-i], 1'b0});
            end
        end
        rd = 1'b0; dev_ready = 7'b0000000;
        @(negedge clk);
        n_cmp++;
        if ({busy, did} !== 4'b0010) begin n_err++; $display("FAIL b2b_end: got %b want 0010", {busy, did}); end
    endtask

    task automatic test_reset_mid();
        wr = 1'b1; addr = 16'h4000; dev_ready = 7'b0000000;
        @(negedge clk);
        n_cmp++;
        if ({busy, dev_sel} !== 8'b1_0010000) begin n_err++; $display("FAIL rstmid_access: got %b want 10010000", {busy, dev_sel}); end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, err, dev_sel, dev_wr, hit} !== 12'h000) begin
            n_err++; $display("FAIL rstmid_clear: got %b want 000000000000", {busy, done, err, dev_sel, dev_wr, hit});
        end
        wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL rstmid_nodone%0d: got %b want 00", i, {busy, done}); end
        end
        rd = 1'b1; addr = 16'h0000; dev_ready = 7'b0000001;
        @(negedge clk);
        n_cmp++;
        if ({dev_sel, dev_rd, hit, did} !== 12'b0000001_1_1000) begin
            n_err++; $display("FAIL rstmid_fresh_access: got %b want 000000111000", {dev_sel, dev_rd, hit, did});
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done, err} !== 3'b110) begin n_err++; $display("FAIL rstmid_fresh_done: got %b want 110", {busy, done, err}); end
        rd = 1'b0; dev_ready = 7'b0000000;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_fresh_idle: got %b want 0", busy); end
    endtask

`ifdef BUS_DECODE_TIMEOUT_EN
    task automatic test_timeout();
        rd = 1'b1; addr = 16'h3000; dev_ready = 7'b0000100;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, err, dev_sel} !== 9'b10_0001000) begin
                n_err++; $display("FAIL timeout_wait%0d: got %b want 100001000", i, {busy, err, dev_sel});
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done, err, hit, did} !== 7'b111_1011) begin
            n_err++; $display("FAIL timeout_err: got %b want 1111011", {busy, done, err, hit, did});
        end
        rd = 1'b0; dev_ready = 7'b0000000;
        @(negedge clk);
        n_cmp++;
        if ({busy, err} !== 2'b00) begin n_err++; $display("FAIL timeout_end: got %b want 00", {busy, err}); end
    endtask
`endif

    initial begin
        test_reset();
        @(negedge clk);
        test_read();
        test_write();
        test_unmapped();
        test_back_to_back();
`ifdef BUS_DECODE_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
